// File: rtl/multicycle_ctrl_gen.sv
// Multicycle control FSM for a small RV32 subset: decodes the IR, sequences
// the datapath through fetch/execute/memory/write-back, and traps on illegal ops or memory timeouts.
module multicycle_ctrl_gen #(
    parameter int   CNT_W       = 32,
    parameter int   MEM_TIMEOUT = 15,
    parameter logic EN_SHIFT    = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instruction,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             alu_src_a,
    output logic             load_ir,
    output logic             load_reg_a,
    output logic             load_reg_b,
    output logic             load_alu_out,
    output logic             load_mdr,
    output logic             write_reg,
    output logic             dmem_write,
    output logic             mem_req,
    output logic             epc_write,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_funct,
    output logic [2:0]       mem_to_reg,
    output logic [1:0]       branch_op,
    output logic [1:0]       shift_control,
    output logic [1:0]       cause,
    output logic             halted,
    output logic [4:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [4:0] {
        S_FETCH     = 5'd0,
        S_DECODE    = 5'd1,
        S_ADDR      = 5'd2,
        S_EXEC_R    = 5'd3,
        S_EXEC_I    = 5'd4,
        S_MEM_RD    = 5'd5,
        S_MEM_WR    = 5'd6,
        S_WB_ALU    = 5'd7,
        S_WB_MEM    = 5'd8,
        S_WB_LUI    = 5'd9,
        S_BRANCH    = 5'd10,
        S_JAL_LINK  = 5'd11,
        S_JAL_PC    = 5'd12,
        S_JALR_CALC = 5'd13,
        S_SHIFT_WB  = 5'd14,
        S_SLT_WB    = 5'd15,
        S_EXCEPT    = 5'd16,
        S_HALT      = 5'd17
    } state_t;

    typedef enum logic [4:0] {
        K_ADD, K_SUB, K_AND, K_SLT, K_SLTI, K_ADDI, K_NOP, K_LOAD, K_STORE,
        K_SLLI, K_SRLI, K_SRAI, K_LUI, K_BEQ, K_BNE, K_BLT, K_BGE,
        K_JAL, K_JALR, K_EBREAK, K_BAD_OP, K_BAD_FN
    } kind_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       alu_src_a;
        logic       load_reg_a;
        logic       load_reg_b;
        logic       load_alu_out;
        logic       write_reg;
        logic       dmem_write;
        logic       mem_req;
        logic       epc_write;
        logic       halted;
        logic [1:0] pc_src;
        logic [1:0] alu_src_b;
        logic [2:0] alu_funct;
        logic [2:0] mem_to_reg;
        logic [1:0] branch_op;
        logic [1:0] shift_control;
    } ctrl_t;

    state_t            state_q;
    state_t            next_state;
    kind_t             kind;
    ctrl_t             ctrl_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout;
    logic              mem_wait_state;
    logic              trap;
    logic [1:0]        trap_cause;

    // Control word for a given state; unnamed outputs stay 0.
    function automatic ctrl_t ctrl_of(input state_t s, input kind_t k);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_b = 2'b01;
                c.alu_funct = 3'b001;
            end
            S_DECODE: begin
                c.load_reg_a   = 1'b1;
                c.load_reg_b   = 1'b1;
                c.load_alu_out = 1'b1;
                c.alu_src_b    = 2'b11;
                c.alu_funct    = 3'b001;
            end
            S_EXEC_R: begin
                c.alu_src_a    = 1'b1;
                c.load_alu_out = 1'b1;
                c.alu_funct    = (k == K_SUB) ? 3'b010 : (k == K_AND) ? 3'b011 : 3'b001;
            end
            S_ADDR: begin
                c.alu_src_a    = 1'b1;
                c.alu_src_b    = 2'b10;
                c.alu_funct    = 3'b001;
                c.load_alu_out = 1'b1;
            end
            S_MEM_RD: c.mem_req = 1'b1;
            S_MEM_WR: begin
                c.mem_req    = 1'b1;
                c.dmem_write = 1'b1;
            end
            S_WB_ALU: c.write_reg = 1'b1;
            S_WB_MEM: begin
                c.write_reg  = 1'b1;
                c.mem_to_reg = 3'b001;
            end
            S_WB_LUI: begin
                c.write_reg  = 1'b1;
                c.mem_to_reg = 3'b010;
            end
            S_JAL_LINK: begin
                c.write_reg  = 1'b1;
                c.mem_to_reg = 3'b011;
            end
            S_SHIFT_WB: begin
                c.write_reg     = 1'b1;
                c.mem_to_reg    = 3'b100;
                c.shift_control = (k == K_SRLI) ? 2'b01 : (k == K_SRAI) ? 2'b10 : 2'b00;
            end
            S_SLT_WB: begin
                c.write_reg  = 1'b1;
                c.mem_to_reg = 3'b101;
                c.alu_src_a  = 1'b1;
                c.alu_funct  = 3'b010;
                c.alu_src_b  = (k == K_SLTI) ? 2'b10 : 2'b00;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_funct     = 3'b010;
                c.pc_write_cond = 1'b1;
                c.pc_src        = 2'b01;
                c.branch_op     = (k == K_BNE) ? 2'b01 : (k == K_BGE) ? 2'b10 :
                                  (k == K_BLT) ? 2'b11 : 2'b00;
            end
            S_JALR_CALC: begin
                c.alu_src_a    = 1'b1;
                c.alu_src_b    = 2'b11;
                c.alu_funct    = 3'b001;
                c.load_alu_out = 1'b1;
            end
            S_JAL_PC: begin
                c.pc_write = 1'b1;
                c.pc_src   = 2'b01;
            end
            S_EXCEPT: begin
                c.epc_write = 1'b1;
                c.pc_write  = 1'b1;
                c.pc_src    = 2'b10;
            end
            S_HALT: c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // Instruction classification straight from the IR, which is stable outside FETCH.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        kind = K_BAD_OP;
        case (instruction[6:0])
            7'b0110011: begin
                kind = K_BAD_FN;
                case (instruction[14:12])
                    3'b000: if (instruction[31:25] == 7'b0000000) kind = K_ADD;
                            else if (instruction[31:25] == 7'b0100000) kind = K_SUB;
                    3'b111: if (instruction[31:25] == 7'b0000000) kind = K_AND;
                    3'b010: if (instruction[31:25] == 7'b0000000) kind = K_SLT;
                    default: kind = K_BAD_FN;
                endcase
            end
            7'b0010011: begin
                kind = K_BAD_FN;
                case (instruction[14:12])
                    3'b000: kind = (instruction[11:7] == 5'd0) ? K_NOP : K_ADDI;
                    3'b010: kind = K_SLTI;
                    3'b001: if (EN_SHIFT && instruction[31:25] == 7'b0000000) kind = K_SLLI;
                    3'b101: if (EN_SHIFT && instruction[31:25] == 7'b0000000) kind = K_SRLI;
                            else if (EN_SHIFT && instruction[31:25] == 7'b0100000) kind = K_SRAI;
                    default: kind = K_BAD_FN;
                endcase
            end
            7'b0000011: kind = (instruction[14:12] == 3'b010) ? K_LOAD : K_BAD_FN;
            7'b0100011: kind = (instruction[14:12] == 3'b010) ? K_STORE : K_BAD_FN;
            7'b0110111: kind = K_LUI;
            7'b1100011: begin
                case (instruction[14:12])
                    3'b000:  kind = K_BEQ;
                    3'b001:  kind = K_BNE;
                    3'b100:  kind = K_BLT;
                    3'b101:  kind = K_BGE;
                    default: kind = K_BAD_FN;
                endcase
            end
            7'b1101111: kind = K_JAL;
            7'b1100111: kind = (instruction[14:12] == 3'b000) ? K_JALR : K_BAD_FN;
            7'b1110011: kind = (instruction == 32'h0010_0073) ? K_EBREAK : K_BAD_FN;
            default:    kind = K_BAD_OP;
        endcase
    end

    assign mem_wait_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign timeout        = (wait_cnt == WAIT_W'(MEM_TIMEOUT)) && !mem_ready;

    always_comb begin
        next_state = state_q;
        trap       = 1'b0;
        trap_cause = 2'b00;
        case (state_q)
            S_FETCH, S_MEM_RD, S_MEM_WR: begin
                // A ready in the timeout cycle still completes the access.
                if (mem_ready) begin
                    next_state = (state_q == S_FETCH)  ? S_DECODE :
                                 (state_q == S_MEM_RD) ? S_WB_MEM : S_FETCH;
                end else if (timeout) begin
                    next_state = S_EXCEPT;
                    trap       = 1'b1;
                    trap_cause = 2'b10;
                end
            end
            S_DECODE: begin
                case (kind)
                    K_ADD, K_SUB, K_AND:           next_state = S_EXEC_R;
                    K_SLT, K_SLTI:                 next_state = S_SLT_WB;
                    K_ADDI, K_LOAD, K_STORE:       next_state = S_ADDR;
                    K_NOP:                         next_state = S_FETCH;
                    K_SLLI, K_SRLI, K_SRAI:        next_state = S_SHIFT_WB;
                    K_LUI:                         next_state = S_WB_LUI;
                    K_BEQ, K_BNE, K_BLT, K_BGE:    next_state = S_BRANCH;
                    K_JAL, K_JALR:                 next_state = S_JAL_LINK;
                    K_EBREAK:                      next_state = S_HALT;
                    K_BAD_FN: begin
                        next_state = S_EXCEPT;
                        trap       = 1'b1;
                        trap_cause = 2'b01;
                    end
                    default: begin
                        next_state = S_EXCEPT;
                        trap       = 1'b1;
                        trap_cause = 2'b00;
                    end
                endcase
            end
            S_EXEC_R:    next_state = S_WB_ALU;
            S_ADDR:      next_state = (kind == K_LOAD)  ? S_MEM_RD :
                                      (kind == K_STORE) ? S_MEM_WR : S_WB_ALU;
            S_JAL_LINK:  next_state = (kind == K_JALR) ? S_JALR_CALC : S_JAL_PC;
            S_JALR_CALC: next_state = S_JAL_PC;
            S_HALT:      next_state = S_HALT;
            default:     next_state = S_FETCH;
        endcase
    end

    // NOTE: the control word is registered from next_state, so it always matches state_q.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            ctrl_q   <= ctrl_of(S_FETCH, K_NOP);
            cause    <= 2'b00;
            retired  <= '0;
            wait_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state_q <= next_state;
            ctrl_q  <= ctrl_of(next_state, kind);
            if (trap)
                cause <= trap_cause;
            if (next_state == S_FETCH && state_q != S_FETCH && state_q != S_EXCEPT)
                retired <= retired + CNT_W'(1);
            if (next_state != state_q &&
                (next_state == S_FETCH || next_state == S_MEM_RD || next_state == S_MEM_WR))
                wait_cnt <= '0;
            else if (mem_wait_state && !mem_ready)
                wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Ready-qualified strobes for the fetch and load-data paths.
    assign load_ir       = (state_q == S_FETCH) && mem_ready;
    assign pc_write      = ctrl_q.pc_write || load_ir;
    assign load_mdr      = (state_q == S_MEM_RD) && mem_ready;
    assign pc_write_cond = ctrl_q.pc_write_cond;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign load_reg_a    = ctrl_q.load_reg_a;
    assign load_reg_b    = ctrl_q.load_reg_b;
    assign load_alu_out  = ctrl_q.load_alu_out;
    assign write_reg     = ctrl_q.write_reg;
    assign dmem_write    = ctrl_q.dmem_write;
    assign mem_req       = ctrl_q.mem_req;
    assign epc_write     = ctrl_q.epc_write;
    assign pc_src        = ctrl_q.pc_src;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign alu_funct     = ctrl_q.alu_funct;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign branch_op     = ctrl_q.branch_op;
    assign shift_control = ctrl_q.shift_control;
    assign halted        = ctrl_q.halted;
    assign state         = state_q;

endmodule
